// File: rtl/mips_pkg.sv
// Shared types and defaults for the data-memory arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  // Wide enough for the largest starvation limit (15).
  localparam int STARVE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_arb_prio.sv
// CPU-priority arbiter with a DMA starvation counter that forces a DMA win.
// Latency: winner is combinational; starve_cnt updates on the grant edge.
// Backpressure: none; only counts when the grant strobe marks a real arbitration.
module dmem_arb_prio
  import mips_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req,
  input  logic                dma_req,
  input  logic                grant,
  output owner_e              winner,
  output logic [STARVE_W-1:0] starve_cnt
);

  localparam logic [STARVE_W-1:0] LIM = STARVE_W'(STARVE_LIM);

  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  // DMA wins when alone, or when it has lost STARVE_LIM arbitrations in a row.
  assign winner     = (dma_req && (!cpu_req || (starve_cnt_q == LIM))) ? OWN_DMA : OWN_CPU;
  assign starve_cnt = starve_cnt_q;

  // Count DMA losses (saturating), clear on every DMA grant.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant) begin
      if (winner == OWN_DMA) begin
        starve_cnt_d = '0;
      end else if (dma_req && (starve_cnt_q != LIM)) begin
        starve_cnt_d = starve_cnt_q + STARVE_W'(1);
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU and a loader/DMA port.
// Latency: req in IDLE (cycle 0) -> mem_en cycle 1 -> ready pulse + rdata cycle 2.
// Backpressure: requester holds req/fields until ready; cpu_stall holds the PC meanwhile.
module dmem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_LIM = 4
) (
  input  logic              Globalclk,
  input  logic              Globalreset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              winner;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
  logic                grant;
  // Kept as a named net so the starvation state is visible for debug.
  logic [STARVE_W-1:0] starve_cnt_unused;

  // Arbitration happens only in IDLE; any request there starts an access.
  assign grant = (state_q == IDLE) && (cpu_req || dma_req);

  dmem_arb_prio #(
    .STARVE_LIM (STARVE_LIM)
  ) u_prio (
    .clk        (Globalclk),
    .rst_n      (Globalreset),
    .cpu_req    (cpu_req),
    .dma_req    (dma_req),
    .grant      (grant),
    .winner     (winner),
    .starve_cnt (starve_cnt_unused)
  );

  // Next state, field latching at grant, and read-data capture at ACC->RESP.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ACC;
          owner_d = winner;
          if (winner == OWN_DMA) begin
            we_d    = dma_we;
            addr_d  = dma_addr;
            wdata_d = dma_wdata;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
        end
      end
      ACC: begin
        state_d = RESP;
        if (!we_q) begin
          if (owner_q == OWN_DMA) begin
            dma_rdata_d = mem_rdata;
          end else begin
            cpu_rdata_d = mem_rdata;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched access fields; reset aborts any in-flight access.
  always_ff @(posedge Globalclk or negedge Globalreset) begin
    if (!Globalreset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Memory command is live only in ACC, so mem_en can never be adjacent.
  assign mem_en    = (state_q == ACC);
  assign mem_we    = (state_q == ACC) && we_q;
  assign mem_addr  = (state_q == ACC) ? addr_q : '0;
  assign mem_wdata = (state_q == ACC) ? wdata_q : '0;

  assign cpu_ready = (state_q == RESP) && (owner_q == OWN_CPU);
  assign dma_ready = (state_q == RESP) && (owner_q == OWN_DMA);
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_stall = cpu_req && !cpu_ready;

endmodule
